// File: rtl/floo_narrow_wide_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floo_narrow_wide_pkg
//  Description : Flit type definitions for the narrow (req/rsp) and wide
//                mesh channels. Every flit carries a header whose 'last'
//                bit marks the final flit of a packet.
//  Revision    : 1.0  initial release
// ============================================================================
package floo_narrow_wide_pkg;

    typedef struct packed {
        logic       last;
        logic [3:0] dst_id;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] data;
    } floo_req_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [15:0] data;
    } floo_rsp_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [63:0] data;
    } floo_wide_t;

endpackage
`default_nettype wire

// File: rtl/floo_link_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : floo_link_chan_fifo
//  Description : One channel of the tile link buffer. A Depth-entry FIFO
//                with no bypass (latency 1), plus tracking of whether a
//                packet is currently open on the input side. Input
//                acceptance is additionally gated by gate_open_i.
//  Ports       : clk_i, rst_ni     clock, synchronous active-low reset
//                gate_open_i       1 = input side may accept flits
//                valid_i/ready_o/data_i   upstream handshake + payload
//                valid_o/ready_i/data_o   downstream handshake + payload
//                in_pkt_o          1 = a packet has started but not ended
//                empty_o           1 = no flit buffered
//  Revision    : 1.0  initial release
// ============================================================================
module floo_link_chan_fifo
    import floo_narrow_wide_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         flit_t = floo_req_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  gate_open_i,
    input  logic  valid_i,
    output logic  ready_o,
    input  flit_t data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output flit_t data_o,
    output logic  in_pkt_o,
    output logic  empty_o
);

    localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_cnt_w = $clog2(Depth) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(Depth);

    flit_t              r_mem [Depth];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_in_pkt;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    // ready depends only on registered state and the gate, never on ready_i;
    // a pop while full frees the slot for the following cycle only.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_cnt_full);
    assign ready_o  = !w_full && gate_open_i;
    assign valid_o  = !w_empty;
    assign w_push   = valid_i && ready_o;
    assign w_pop    = valid_o && ready_i;
    assign data_o   = r_mem[r_rptr];
    assign in_pkt_o = r_in_pkt;
    assign empty_o  = w_empty;

    // Storage is not reset; the count decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + c_ptr_one;
                r_in_pkt <= !data_i.hdr.last;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Upstream must hold valid and payload until the flit is taken.
    a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> valid_i);
    a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> $stable(data_i));
`endif

endmodule
`default_nettype wire

// File: rtl/floo_tile_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : floo_tile_link_buffer
//  Description : Elastic, isolatable buffer on one mesh link between two
//                tiles. Retimes the narrow req, narrow rsp and wide channels
//                and provides a packet-safe isolate/drain handshake: once
//                isolation is requested, open packets may finish but no new
//                packet is accepted; isolated_o rises once every channel is
//                idle and empty. The downstream side is never gated.
//  Ports       : clk_i, rst_ni     clock, synchronous active-low reset
//                isolate_i         level request to drain and isolate
//                isolated_o        1 = isolated, inputs blocked
//                busy_o            1 = any channel FIFO non-empty
//                {req,rsp,wide}_valid_i/_ready_o/_i  upstream side
//                {req,rsp,wide}_valid_o/_ready_i/_o  downstream side
//  Revision    : 1.0  initial release
// ============================================================================
module floo_tile_link_buffer
    import floo_narrow_wide_pkg::*;
#(
    parameter int unsigned Depth       = 2,
    parameter type         flit_req_t  = floo_req_t,
    parameter type         flit_rsp_t  = floo_rsp_t,
    parameter type         flit_wide_t = floo_wide_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       isolate_i,
    output logic       isolated_o,
    output logic       busy_o,

    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  flit_req_t  req_i,
    output logic       req_valid_o,
    input  logic       req_ready_i,
    output flit_req_t  req_o,

    input  logic       rsp_valid_i,
    output logic       rsp_ready_o,
    input  flit_rsp_t  rsp_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output flit_rsp_t  rsp_o,

    input  logic       wide_valid_i,
    output logic       wide_ready_o,
    input  flit_wide_t wide_i,
    output logic       wide_valid_o,
    input  logic       wide_ready_i,
    output flit_wide_t wide_o
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_drain    = 2'd1;
    localparam logic [1:0] c_st_isolated = 2'd2;

    // Channel index: 0 = req, 1 = rsp, 2 = wide.
    logic [1:0] r_state;
    logic       r_isolated;
    logic       r_alive;
    logic [2:0] w_in_pkt;
    logic [2:0] w_empty;
    logic [2:0] w_gate;
    logic       w_all_idle;

    // r_alive holds all inputs closed during reset and for the release cycle.
    always_comb begin
        w_gate = 3'b000;
        if (r_alive) begin
            case (r_state)
                c_st_run:   w_gate = 3'b111;
                c_st_drain: w_gate = w_in_pkt;
                default:    w_gate = 3'b000;
            endcase
        end
    end

    assign w_all_idle = (w_in_pkt == 3'b000) && (w_empty == 3'b111);
    assign busy_o     = (w_empty != 3'b111);
    assign isolated_o = r_isolated;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= c_st_run;
            r_isolated <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                c_st_run: begin
                    if (isolate_i) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // Dropping the request wins over completing the drain.
                    if (!isolate_i) begin
                        r_state <= c_st_run;
                    end else if (w_all_idle) begin
                        r_state    <= c_st_isolated;
                        r_isolated <= 1'b1;
                    end
                end
                c_st_isolated: begin
                    if (!isolate_i) begin
                        r_state    <= c_st_run;
                        r_isolated <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_st_run;
                    r_isolated <= 1'b0;
                end
            endcase
        end
    end

    floo_link_chan_fifo #(
        .Depth  (Depth),
        .flit_t (flit_req_t)
    ) u_req_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .gate_open_i (w_gate[0]),
        .valid_i     (req_valid_i),
        .ready_o     (req_ready_o),
        .data_i      (req_i),
        .valid_o     (req_valid_o),
        .ready_i     (req_ready_i),
        .data_o      (req_o),
        .in_pkt_o    (w_in_pkt[0]),
        .empty_o     (w_empty[0])
    );

    floo_link_chan_fifo #(
        .Depth  (Depth),
        .flit_t (flit_rsp_t)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .gate_open_i (w_gate[1]),
        .valid_i     (rsp_valid_i),
        .ready_o     (rsp_ready_o),
        .data_i      (rsp_i),
        .valid_o     (rsp_valid_o),
        .ready_i     (rsp_ready_i),
        .data_o      (rsp_o),
        .in_pkt_o    (w_in_pkt[1]),
        .empty_o     (w_empty[1])
    );

    floo_link_chan_fifo #(
        .Depth  (Depth),
        .flit_t (flit_wide_t)
    ) u_wide_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .gate_open_i (w_gate[2]),
        .valid_i     (wide_valid_i),
        .ready_o     (wide_ready_o),
        .data_i      (wide_i),
        .valid_o     (wide_valid_o),
        .ready_i     (wide_ready_i),
        .data_o      (wide_o),
        .in_pkt_o    (w_in_pkt[2]),
        .empty_o     (w_empty[2])
    );

endmodule
`default_nettype wire
